// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard slice.
//   REG_W / NUM_REGS : architectural register index width and count.
//   FWD_SEL_RF       : forwarding select value meaning "use the register file".
//   PACK_W           : width packed register-index vectors are widened to before
//                      reg_field() extraction.
//   sel_width()      : width of one forwarding select for a given stage count.
//   reg_field()      : pulls the idx-th REG_W-bit field out of a packed vector.
package hazard_pkg;

  localparam int unsigned REG_W      = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned FWD_SEL_RF = 0;
  localparam int unsigned PACK_W     = NUM_REGS * REG_W;

  // One code per forwarding stage plus the register-file code, never narrower than 1 bit.
  function automatic int unsigned sel_width(input int unsigned stages);
    int unsigned w;
    w = $clog2(stages + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic [REG_W-1:0] reg_field(input logic [PACK_W-1:0] vec,
                                                 input int unsigned       idx);
    return vec[idx*REG_W +: REG_W];
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Forwarding priority scan for one EX-stage read port.
//   rs_i      : EX-stage source register of this port.
//   fwd_rd_i  : destination register per forwardable stage, stage 0 (youngest) at the LSBs.
//   fwd_we_i  : register-write flag per stage.
//   fwd_rdy_i : result data present per stage.
//   sel_o     : 0 = register file, k = stage k-1.
//   not_rdy_o : the winning stage has no data yet.
module fwd_select import hazard_pkg::*; #(
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned SEL_W      = sel_width(FWD_STAGES)
) (
  input  logic [REG_W-1:0]            rs_i,
  input  logic [FWD_STAGES*REG_W-1:0] fwd_rd_i,
  input  logic [FWD_STAGES-1:0]       fwd_we_i,
  input  logic [FWD_STAGES-1:0]       fwd_rdy_i,
  output logic [SEL_W-1:0]            sel_o,
  output logic                        not_rdy_o
);

  logic [PACK_W-1:0] rd_wide;
  logic              found;

  assign rd_wide = PACK_W'(fwd_rd_i);

  // Youngest stage wins: it holds the most recent write to rs.
  always_comb begin
    sel_o     = SEL_W'(FWD_SEL_RF);
    not_rdy_o = 1'b0;
    found     = 1'b0;
    for (int unsigned k = 0; k < FWD_STAGES; k++) begin
      if (!found && fwd_we_i[k] && (rs_i != '0) && (reg_field(rd_wide, k) == rs_i)) begin
        found     = 1'b1;
        sel_o     = SEL_W'(k + 1);
        not_rdy_o = !fwd_rdy_i[k];
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// N-port forwarding selector plus per-register latency scoreboard, between ID and EX.
//   issue_*        : instruction in ID and its destination/latency.
//   id_rs/_used    : ID-stage sources checked against the scoreboard -> stall.
//   flush          : squashes the instruction that entered EX last cycle and the ID one.
//   ex_rs, fwd_*   : EX sources and per-stage writer info -> fwd_sel per port.
//   stall          : hold PC and IF/ID, bubble into EX.
//   hazard_err     : sticky, a forwarding match hit a stage without data.
// Optional (HAZARD_PERF_EN): stall_cycles and fwd_hits saturating 32-bit counters.
module hazard_scoreboard import hazard_pkg::*; #(
  parameter int unsigned NUM_RS     = 2,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned LAT_W      = 3,
  parameter int unsigned SEL_W      = sel_width(FWD_STAGES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        issue_valid,
  input  logic                        issue_reg_write,
  input  logic [REG_W-1:0]            issue_rd,
  input  logic [LAT_W-1:0]            issue_lat,
  input  logic [NUM_RS*REG_W-1:0]     id_rs,
  input  logic [NUM_RS-1:0]           id_rs_used,
  input  logic                        flush,
  input  logic [NUM_RS*REG_W-1:0]     ex_rs,
  input  logic [FWD_STAGES*REG_W-1:0] fwd_rd,
  input  logic [FWD_STAGES-1:0]       fwd_we,
  input  logic [FWD_STAGES-1:0]       fwd_rdy,
  output logic [NUM_RS*SEL_W-1:0]     fwd_sel,
  output logic                        stall,
  output logic                        hazard_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]                 stall_cycles,
  output logic [31:0]                 fwd_hits
`endif
);

  logic [LAT_W-1:0] busy_q   [NUM_REGS];
  logic [LAT_W-1:0] busy_d   [NUM_REGS];
  logic [LAT_W-1:0] dec_cnt  [NUM_REGS];
  logic [REG_W-1:0] last_rd_q, last_rd_d;
  logic [LAT_W-1:0] last_prev_q, last_prev_d;
  logic             last_vld_q, last_vld_d;
  logic             hazard_err_q;
  logic [LAT_W-1:0] lat_eff;
  logic             issue_fire;
  logic [NUM_RS-1:0] port_not_rdy;
  logic [PACK_W-1:0] id_rs_wide;
  logic [PACK_W-1:0] ex_rs_wide;

  assign id_rs_wide = PACK_W'(id_rs);
  assign ex_rs_wide = PACK_W'(ex_rs);

  // A count above 1 means the producer result will not be forwardable when the
  // consumer reaches EX next cycle.
  always_comb begin
    stall = 1'b0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      if (id_rs_used[i] && (reg_field(id_rs_wide, i) != '0) &&
          (busy_q[reg_field(id_rs_wide, i)] > LAT_W'(1))) begin
        stall = 1'b1;
      end
    end
  end

  assign lat_eff    = (issue_lat == '0) ? LAT_W'(1) : issue_lat;
  assign issue_fire = issue_valid & issue_reg_write & (issue_rd != '0) & ~stall & ~flush;

  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      dec_cnt[r] = (busy_q[r] != '0) ? busy_q[r] - LAT_W'(1) : '0;
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      busy_d[r] = dec_cnt[r];
    end
    last_rd_d   = last_rd_q;
    last_prev_d = last_prev_q;
    last_vld_d  = 1'b0;
    if (issue_fire) begin
      // Keep the larger count so an older, slower write to the same rd stays covered.
      busy_d[issue_rd] = (lat_eff > dec_cnt[issue_rd]) ? lat_eff : dec_cnt[issue_rd];
      last_rd_d   = issue_rd;
      last_prev_d = dec_cnt[issue_rd];
      last_vld_d  = 1'b1;
    end
    // Undo the squashed issue; its saved count has aged one more cycle since.
    if (flush && last_vld_q) begin
      busy_d[last_rd_q] = (last_prev_q != '0) ? last_prev_q - LAT_W'(1) : '0;
    end
    busy_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        busy_q[r] <= '0;
      end
      last_rd_q    <= '0;
      last_prev_q  <= '0;
      last_vld_q   <= 1'b0;
      hazard_err_q <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        busy_q[r] <= busy_d[r];
      end
      last_rd_q    <= last_rd_d;
      last_prev_q  <= last_prev_d;
      last_vld_q   <= last_vld_d;
      hazard_err_q <= hazard_err_q | (|port_not_rdy);
    end
  end

  assign hazard_err = hazard_err_q;

  for (genvar i = 0; i < NUM_RS; i++) begin : g_port
    logic [REG_W-1:0] port_rs;
    assign port_rs = reg_field(ex_rs_wide, i);

    fwd_select #(
      .FWD_STAGES (FWD_STAGES),
      .SEL_W      (SEL_W)
    ) u_fwd_select (
      .rs_i      (port_rs),
      .fwd_rd_i  (fwd_rd),
      .fwd_we_i  (fwd_we),
      .fwd_rdy_i (fwd_rdy),
      .sel_o     (fwd_sel[i*SEL_W +: SEL_W]),
      .not_rdy_o (port_not_rdy[i])
    );
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] fwd_hits_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      fwd_hits_q     <= '0;
    end else begin
      if (stall && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if ((|fwd_sel) && (fwd_hits_q != '1)) begin
        fwd_hits_q <= fwd_hits_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign fwd_hits     = fwd_hits_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_reg_write;
  logic [4:0]  issue_rd;
  logic [2:0]  issue_lat;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic        flush;
  logic [9:0]  ex_rs;
  logic [9:0]  fwd_rd;
  logic [1:0]  fwd_we;
  logic [1:0]  fwd_rdy;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic        hazard_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] fwd_hits;
`endif

  hazard_scoreboard dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .issue_valid     (issue_valid),
    .issue_reg_write (issue_reg_write),
    .issue_rd        (issue_rd),
    .issue_lat       (issue_lat),
    .id_rs           (id_rs),
    .id_rs_used      (id_rs_used),
    .flush           (flush),
    .ex_rs           (ex_rs),
    .fwd_rd          (fwd_rd),
    .fwd_we          (fwd_we),
    .fwd_rdy         (fwd_rdy),
    .fwd_sel         (fwd_sel),
    .stall           (stall),
    .hazard_err      (hazard_err)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles    (stall_cycles),
    .fwd_hits        (fwd_hits)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model: plain integer counts per architectural register.
  int      m_busy[32];
  int      m_lrd;
  int      m_lprev;
  bit      m_lvld;
  bit      m_err;
  longint  m_stalls;
  longint  m_hits;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int id_src(input int p);
    return int'(id_rs[p*5 +: 5]);
  endfunction

  function automatic int ex_src(input int p);
    return int'(ex_rs[p*5 +: 5]);
  endfunction

  function automatic int stage_rd(input int k);
    return int'(fwd_rd[k*5 +: 5]);
  endfunction

  function automatic bit model_stall();
    for (int p = 0; p < 2; p++) begin
      if (id_rs_used[p] && id_src(p) != 0 && m_busy[id_src(p)] > 1) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Returns 0 for register file, k+1 for the youngest matching writer stage k.
  function automatic int model_sel(input int p);
    if (ex_src(p) == 0) return 0;
    for (int k = 0; k < 2; k++) begin
      if (fwd_we[k] && stage_rd(k) == ex_src(p)) return k + 1;
    end
    return 0;
  endfunction

  function automatic bit model_notrdy();
    for (int p = 0; p < 2; p++) begin
      if (model_sel(p) != 0 && !fwd_rdy[model_sel(p) - 1]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_busy[r] = 0;
    m_lrd = 0; m_lprev = 0; m_lvld = 1'b0; m_err = 1'b0;
    m_stalls = 0; m_hits = 0;
  endtask

  task automatic model_update();
    int  nb[32];
    int  lat;
    bit  st;
    bit  fire;
    int  rd;
    if (!rst_n) return;
    st   = model_stall();
    rd   = int'(issue_rd);
    lat  = (issue_lat == 0) ? 1 : int'(issue_lat);
    fire = issue_valid && issue_reg_write && rd != 0 && !st && !flush;
    for (int r = 0; r < 32; r++) nb[r] = (m_busy[r] > 0) ? m_busy[r] - 1 : 0;
    if (flush && m_lvld) nb[m_lrd] = (m_lprev > 0) ? m_lprev - 1 : 0;
    if (fire) begin
      m_lprev = nb[rd];
      nb[rd]  = (lat > nb[rd]) ? lat : nb[rd];
      m_lrd   = rd;
      m_lvld  = 1'b1;
    end else begin
      m_lvld = 1'b0;
    end
    for (int r = 0; r < 32; r++) m_busy[r] = nb[r];
    if (model_notrdy()) m_err = 1'b1;
    if (st && m_stalls < 64'hFFFF_FFFF) m_stalls++;
    if ((model_sel(0) != 0 || model_sel(1) != 0) && m_hits < 64'hFFFF_FFFF) m_hits++;
  endtask

  // Advance one clock; model follows the edge, inputs may change 2 time units later.
  task automatic step();
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_reg_write = 1'b0; issue_rd = '0; issue_lat = '0;
    id_rs = '0; id_rs_used = '0; flush = 1'b0; ex_rs = '0;
    fwd_rd = '0; fwd_we = '0; fwd_rdy = '1;
  endtask

  task automatic drive_issue(input int rd, input int lat);
    issue_valid = 1'b1; issue_reg_write = 1'b1;
    issue_rd = 5'(rd); issue_lat = 3'(lat);
  endtask

  task automatic set_id(input int p, input int rs);
    id_rs[p*5 +: 5] = 5'(rs);
    id_rs_used[p]   = 1'b1;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("stall", longint'(stall), longint'(model_stall()));
        chk("fwd_sel0", longint'(fwd_sel[1:0]), longint'(model_sel(0)));
        chk("fwd_sel1", longint'(fwd_sel[3:2]), longint'(model_sel(1)));
        chk("hazard_err", longint'(hazard_err), longint'(m_err));
`ifdef HAZARD_PERF_EN
        chk("stall_cycles", longint'(stall_cycles), m_stalls);
        chk("fwd_hits", longint'(fwd_hits), m_hits);
`endif
      end
    end
  end

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk_en = 1'b1;
    #1;
    chk("reset_stall", longint'(stall), 0);
    chk("reset_fwd_sel", longint'(fwd_sel), 0);
    chk("reset_err", longint'(hazard_err), 0);

    // Load-use with latency 2: exactly one stall cycle.
    drive_issue(5, 2); step();
    idle(); set_id(0, 5); #1;
    chk("lu_stall_first", longint'(stall), 1);
    step(); #1;
    chk("lu_stall_second", longint'(stall), 0);
    idle();
    // ALU latency never stalls.
    drive_issue(6, 1); step();
    idle(); set_id(0, 6); #1;
    chk("alu_no_stall", longint'(stall), 0);
    step(); idle();

    // Forwarding priority on port 1.
    ex_rs[9:5] = 5'd7; fwd_rd = {5'd7, 5'd7}; fwd_we = 2'b11; #1;
    chk("fwd_youngest", longint'(fwd_sel[3:2]), 1);
    fwd_we = 2'b10; #1;
    chk("fwd_older", longint'(fwd_sel[3:2]), 2);
    ex_rs = '0; #1;
    chk("fwd_x0", longint'(fwd_sel[3:2]), 0);
    step(); idle();

    // WAW: older long write keeps the count.
    drive_issue(9, 4); step();
    drive_issue(9, 1); step();
    idle();
    chk("waw_model_cnt", longint'(m_busy[9]), 3);
    set_id(1, 9); #1;
    chk("waw_stall_a", longint'(stall), 1);
    step(); #1;
    chk("waw_stall_b", longint'(stall), 1);
    step(); #1;
    chk("waw_stall_c", longint'(stall), 0);
    step(); idle();

    // Flush restores the pre-issue count.
    drive_issue(3, 3); step();
    idle(); flush = 1'b1; step();
    flush = 1'b0; set_id(0, 3); #1;
    chk("flush_no_stall", longint'(stall), 0);
    chk("flush_model_cnt", longint'(m_busy[3]), 0);
    step(); idle();

    // Match on a stage without data sets the sticky error.
    ex_rs[4:0] = 5'd4; fwd_rd[4:0] = 5'd4; fwd_we = 2'b01; fwd_rdy = 2'b00;
    step(); idle(); #1;
    chk("err_set", longint'(hazard_err), 1);
    step(); #1;
    chk("err_sticky", longint'(hazard_err), 1);

    // Asynchronous reset in the middle of a stall.
    drive_issue(5, 3); step();
    idle(); set_id(0, 5); #1;
    chk("pre_reset_stall", longint'(stall), 1);
    rst_n = 1'b0; model_reset(); #1;
    chk("async_reset_stall", longint'(stall), 0);
    chk("async_reset_err", longint'(hazard_err), 0);
    step(); step();
    rst_n = 1'b1; #1;
    chk("post_reset_stall", longint'(stall), 0);
    step(); idle();

`ifdef HAZARD_PERF_EN
    for (int n = 0; n < 4; n++) begin
      drive_issue(5, 2); step();
      idle(); set_id(0, 5); step(); step(); idle();
    end
    #1;
    chk("perf_four_stalls", longint'(stall_cycles), 4);
`endif

    // Randomized traffic over a small register set to force collisions.
    for (int it = 0; it < 3000; it++) begin
      issue_valid     = 1'($urandom_range(0, 1));
      issue_reg_write = ($urandom_range(0, 3) != 0);
      issue_rd        = 5'($urandom_range(0, 7));
      issue_lat       = 3'($urandom_range(0, 7));
      id_rs           = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_rs_used      = 2'($urandom_range(0, 3));
      flush           = ($urandom_range(0, 7) == 0);
      ex_rs           = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      fwd_rd          = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      fwd_we          = 2'($urandom_range(0, 3));
      fwd_rdy         = {($urandom_range(0, 31) != 0), ($urandom_range(0, 31) != 0)};
      if (it == 1500) begin
        rst_n = 1'b0; model_reset(); #1;
        rst_n = 1'b1;
      end
      step();
    end

    idle();
    step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
